// File: rtl/accel_seq_ctrl.sv
// accel_seq_ctrl: MMIO-driven start/wait sequencer for an accelerator.
// Optional watchdog compiled in with ACCEL_SEQ_TIMEOUT_EN.
module accel_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_start_i,
  input  logic             clear_i,
  input  logic             irq_en_i,
  output logic             accel_start_o,
  input  logic             accel_done_i,
  input  logic             accel_match_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             match_o,
  output logic             timeout_o,
  output logic             overrun_o,
  output logic             irq_o,
  output logic [CNT_W-1:0] job_cnt_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic prev_q;
  logic arm_q;
  logic start_edge;
  logic busy;
  logic fin;
  logic to_hit;

  logic done_q, match_q, ovr_q, tmo_q;
  logic [CNT_W-1:0] job_q, mcnt_q;

  // arm_q blocks a level already high at reset release from
  // looking like a fresh request
  assign start_edge = arm_q & cmd_start_i & ~prev_q;
  assign busy       = (state_q != IDLE);
  assign fin        = (state_q == WAIT) & accel_done_i;

  // Edge-detect history and post-reset arming
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= cmd_start_i;
      if (!cmd_start_i) arm_q <= 1'b1;
    end
  end

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wcnt_q;

  // Cycles spent in WAIT; held at zero elsewhere
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else if (state_q != WAIT) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_q + TW'(1);
    end
  end

  // Done on the last allowed cycle takes priority
  assign to_hit = (state_q == WAIT) & ~accel_done_i &
                  (wcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, set beats clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= 1'b0;
    end else begin
      if (clear_i) tmo_q <= 1'b0;
      if (to_hit)  tmo_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign tmo_q  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (accel_done_i | to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky status flags; a set in the same cycle beats clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q  <= 1'b0;
      match_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (clear_i) begin
        done_q  <= 1'b0;
        match_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (fin) begin
        done_q  <= 1'b1;
        match_q <= accel_match_i;
      end
      if (start_edge & busy) ovr_q <= 1'b1;
    end
  end

  // Saturating completion counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_q  <= '0;
      mcnt_q <= '0;
    end else if (fin) begin
      if (job_q != '1) job_q <= job_q + CNT_W'(1);
      if (accel_match_i && mcnt_q != '1)
        mcnt_q <= mcnt_q + CNT_W'(1);
    end
  end

  assign accel_start_o = (state_q == START);
  assign busy_o        = busy;
  assign done_o        = done_q;
  assign match_o       = match_q;
  assign timeout_o     = tmo_q;
  assign overrun_o     = ovr_q;
  assign irq_o         = irq_en_i & (done_q | tmo_q);
  assign job_cnt_o     = job_q;
  assign match_cnt_o   = mcnt_q;

endmodule
